// File: rtl/capture_controller_if.sv
// Host readout path of capture_controller: pop request in, one sample (plus last flag) out.
interface capture_controller_if #(
    parameter int SAMPLE_WIDTH = 8
);
    logic                    rd_en;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic                    rd_last;

    modport master (output rd_en, input rd_data, input rd_valid, input rd_last);
    modport slave  (input rd_en, output rd_data, output rd_valid, output rd_last);
endinterface

// File: rtl/capture_controller.sv
// Capture sequencer behind trigger_basic: circular pre/post-trigger buffer served to the host.
// Define CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_CYCLES cycles in WAIT.
module capture_controller #(
    parameter int SAMPLE_WIDTH   = 8,
    parameter int DEPTH_LOG2     = 10,
    parameter int TIMEOUT_CYCLES = 2 ** 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DEPTH_LOG2-1:0]   preCount,
    input  logic [DEPTH_LOG2:0]     postCount,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    run,
    output logic                    arm,
    output logic                    busy,
    output logic                    done,
    output logic                    timed_out,
    capture_controller_if.slave     rd
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2+1:0] DEPTH_WIDE = (DEPTH_LOG2 + 2)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("capture_controller: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   pre_len, wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]     post_len, total_len, fill_cnt, remaining, rd_cnt;
    logic [DEPTH_LOG2:0]     post_req, post_clamped;
    logic [DEPTH_LOG2+1:0]   window_req;
    logic                    accept_start, trigger, write_en, pop, timeout_hit;

    // A zero post length still captures the trigger sample; the window never exceeds the buffer.
    always_comb begin
        post_req     = (postCount == '0) ? CNT_ONE : postCount;
        window_req   = {2'b00, preCount} + {1'b0, post_req};
        post_clamped = post_req;
        if (window_req > DEPTH_WIDE)
            post_clamped = (DEPTH_LOG2 + 1)'(DEPTH) - {1'b0, preCount};
    end

    assign total_len = {1'b0, pre_len} + post_len;

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == S_WAIT)
            wait_cnt <= wait_cnt + TW'(1);
        else
            wait_cnt <= '0;
    end

    assign timeout_hit = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        trigger      = 1'b0;
        write_en     = 1'b0;
        pop          = 1'b0;
        arm          = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = S_ARM;
                end
            end
            S_ARM: begin
                busy       = 1'b1;
                next_state = (pre_len == '0) ? S_WAIT : S_PRE;
            end
            S_PRE: begin
                busy     = 1'b1;
                write_en = 1'b1;
                if (fill_cnt == {1'b0, pre_len} - CNT_ONE)
                    next_state = S_WAIT;
            end
            S_WAIT: begin
                busy     = 1'b1;
                arm      = 1'b0;
                write_en = 1'b1;
                if (run || timeout_hit) begin
                    trigger    = 1'b1;
                    next_state = (post_len == CNT_ONE) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                busy     = 1'b1;
                arm      = 1'b0;
                write_en = 1'b1;
                if (remaining == CNT_ONE)
                    next_state = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                pop  = rd.rd_en && (rd_cnt < total_len);
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = S_ARM;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state   = S_IDLE;
            accept_start = 1'b0;
            trigger      = 1'b0;
            pop          = 1'b0;
        end
    end

    // Sample RAM carries no reset so it can map onto block memory.
    always_ff @(posedge clock) begin
        if (write_en)
            mem[wr_ptr] <= dataIn;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_len     <= '0;
            post_len    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_cnt    <= '0;
            remaining   <= '0;
            rd_cnt      <= '0;
            timed_out   <= 1'b0;
            rd.rd_data  <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
        end else begin
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            if (accept_start) begin
                pre_len   <= preCount;
                post_len  <= post_clamped;
                timed_out <= 1'b0;
            end
            if (abort)
                timed_out <= 1'b0;
            case (state)
                S_ARM: begin
                    wr_ptr   <= '0;
                    fill_cnt <= '0;
                end
                S_PRE: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fill_cnt <= fill_cnt + CNT_ONE;
                end
                S_WAIT: wr_ptr <= wr_ptr + 1'b1;
                S_POST: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    remaining <= remaining - CNT_ONE;
                end
                default: ;
            endcase
            // Readout begins pre samples before the trigger sample, wrapping around the buffer.
            if (trigger) begin
                rd_ptr    <= wr_ptr - pre_len;
                remaining <= post_len - CNT_ONE;
                rd_cnt    <= '0;
                if (timeout_hit && !run)
                    timed_out <= 1'b1;
            end
            if (pop) begin
                rd.rd_data  <= mem[rd_ptr];
                rd.rd_valid <= 1'b1;
                rd.rd_last  <= (rd_cnt == total_len - CNT_ONE);
                rd_ptr      <= rd_ptr + 1'b1;
                rd_cnt      <= rd_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller on a 16-deep buffer against a sample-stream model.
// Each capture records the driven stream; the expected readout is a slice around the trigger sample.
module tb_capture_controller;

    localparam int SW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TMO   = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [DL-1:0] preCount;
    logic [DL:0]   postCount;
    logic [SW-1:0] dataIn;
    logic          run;
    logic          arm;
    logic          busy;
    logic          done;
    logic          timed_out;

    int cmpCount = 0;
    int errCount = 0;

    capture_controller_if #(.SAMPLE_WIDTH(SW)) rdBus ();

    capture_controller #(
        .SAMPLE_WIDTH  (SW),
        .DEPTH_LOG2    (DL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .preCount (preCount),
        .postCount(postCount),
        .dataIn   (dataIn),
        .run      (run),
        .arm      (arm),
        .busy     (busy),
        .done     (done),
        .timed_out(timed_out),
        .rd       (rdBus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmpCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_arm"}, arm, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_rd_valid"}, rdBus.rd_valid, 0);
    endtask

    // One full capture plus readout; waitCycles counts WAIT samples before the trigger sample.
    task automatic applyStimulus(input int pre, input int postReq, input int waitCycles,
                                 input bit ramp, input bit pokeStart);
        int         post, trigIdx, total, nSamples;
        bit         useRun;
        logic [7:0] samples[$];
        post = (postReq == 0) ? 1 : postReq;
        if (pre + post > DEPTH) post = DEPTH - pre;
        useRun = 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
        if (waitCycles >= TMO) begin
            waitCycles = TMO - 1;
            useRun     = 1'b0;
        end
`endif
        trigIdx  = pre + waitCycles;
        nSamples = trigIdx + post;
        total    = pre + post;

        @(negedge clock);
        start     = 1'b1;
        preCount  = DL'(pre);
        postCount = (DL + 1)'(postReq);
        @(negedge clock);
        start     = 1'b0;
        preCount  = DL'($urandom);
        postCount = (DL + 1)'($urandom);
        @(negedge clock);
        for (int k = 0; k < nSamples; k++) begin
            dataIn = ramp ? k[7:0] : 8'($urandom);
            samples.push_back(dataIn);
            if (k < pre) begin
                run = 1'($urandom_range(0, 1));
            end else if (k < trigIdx) begin
                run = 1'b0;
            end else if (k == trigIdx) begin
                run = useRun;
                checkOutput("arm_in_wait", arm, 0);
                checkOutput("busy_in_wait", busy, 1);
            end else begin
                run = 1'($urandom_range(0, 1));
            end
            start = pokeStart && (k == pre) && (waitCycles > 0);
            @(negedge clock);
        end
        run   = 1'b0;
        start = 1'b0;
        checkOutput("done_after_capture", done, 1);
        checkOutput("busy_after_capture", busy, 0);
        checkOutput("arm_after_capture", arm, 1);
        checkOutput("timed_out_flag", timed_out, {31'b0, !useRun});

        rdBus.rd_en = 1'b1;
        for (int i = 0; i < total + 2; i++) begin
            @(negedge clock);
            if (i < total) begin
                checkOutput("rd_valid", rdBus.rd_valid, 1);
                checkOutput("rd_data", rdBus.rd_data, samples[trigIdx - pre + i]);
                checkOutput("rd_last", rdBus.rd_last, (i == total - 1) ? 1 : 0);
            end else begin
                checkOutput("rd_valid_past_end", rdBus.rd_valid, 0);
                checkOutput("rd_last_past_end", rdBus.rd_last, 0);
            end
        end
        rdBus.rd_en = 1'b0;
        checkOutput("done_hold", done, 1);
    endtask

    task automatic startAbortTest();
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        preCount  = 4'd2;
        postCount = 5'd2;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        checkIdleOutputs("start_abort");
        @(negedge clock);
        checkOutput("start_abort_busy_later", busy, 0);
    endtask

    task automatic abortInWaitTest();
        @(negedge clock);
        start     = 1'b1;
        preCount  = 4'd1;
        postCount = 5'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("abort_pre_arm", arm, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkIdleOutputs("abort_wait");
    endtask

    task automatic resetMidPostTest();
        @(negedge clock);
        start     = 1'b1;
        preCount  = 4'd2;
        postCount = 5'd8;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 9; k++) begin
            dataIn = 8'($urandom);
            run    = (k == 5);
            @(negedge clock);
        end
        run = 1'b0;
        checkOutput("post_arm_before_reset", arm, 0);
        reset = 1'b1;
        #1;
        checkIdleOutputs("reset_mid_post");
        checkOutput("reset_rd_data", rdBus.rd_data, 0);
        checkOutput("reset_rd_last", rdBus.rd_last, 0);
        checkOutput("reset_timed_out", timed_out, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkIdleOutputs("after_reset_release");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        run         = 1'b0;
        preCount    = '0;
        postCount   = '0;
        dataIn      = '0;
        rdBus.rd_en = 1'b0;
        repeat (2) @(negedge clock);
        checkIdleOutputs("reset");
        checkOutput("reset_rd_data", rdBus.rd_data, 0);
        checkOutput("reset_rd_last", rdBus.rd_last, 0);
        checkOutput("reset_timed_out", timed_out, 0);
        reset = 1'b0;
        @(negedge clock);
        checkIdleOutputs("idle");

        $display("[TB] directed captures");
        applyStimulus(4, 4, 16, 1'b1, 1'b0);
        applyStimulus(0, 0, 7, 1'b1, 1'b0);
        applyStimulus(12, 10, 30, 1'b0, 1'b0);
        applyStimulus(3, 5, 6, 1'b0, 1'b1);
        applyStimulus(0, 31, 3, 1'b0, 1'b0);
        startAbortTest();
        abortInWaitTest();
        resetMidPostTest();
`ifdef CAPTURE_TIMEOUT_EN
        applyStimulus(2, 3, 60, 1'b0, 1'b0);
`endif

        $display("[TB] randomized captures");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 40)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
